// File: rtl/crypto1_keystream.sv
// crypto1_keystream: Crypto1 48-bit LFSR with nonlinear filter, single-step and 32-bit word feed.
module crypto1_keystream (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        KEY_LOAD,
  input  logic [47:0] KEY,
  input  logic        STB,
  input  logic        BIT_IN,
  input  logic        ENC_FB,
  input  logic        WORD_STB,
  input  logic [31:0] WORD_IN,
  input  logic        WORD_ENC,
  output logic        KS_VALID,
  output logic        KS_BIT,
  output logic        WORD_DONE,
  output logic [31:0] KS_WORD,
  output logic        BUSY,
  output logic        KEYED,
  output logic [47:0] STATE
);
  typedef enum logic {IDLE, WORD} fsm_t;
  localparam logic [15:0] FA = 16'h2C79;
  localparam logic [15:0] FB = 16'h6671;
  localparam logic [31:0] FC = 32'h7907287B;
  localparam logic [47:0] TAPS = 48'h0E88_2B0A_D621;
  fsm_t        fsm_q, fsm_d;
  logic [47:0] state_q;
  logic [31:0] word_q, acc_q, acc_d, ks_word_q;
  logic [4:0]  cnt_q;
  logic        enc_q, ks_bit_q, ks_valid_q, word_done_q, keyed_q;
  logic        ks, word_step, single, start, last, fbit, enc, fb_in;
  // Tables are MSB-first, so bit (15 - idx) is simply bit ~idx.
  function automatic logic fa(input logic [3:0] y);
    return FA[~y];
  endfunction
  function automatic logic fb(input logic [3:0] y);
    return FB[~y];
  endfunction
  always_comb begin
    ks = FC[~{fa({state_q[9], state_q[11], state_q[13], state_q[15]}),
              fb({state_q[17], state_q[19], state_q[21], state_q[23]}),
              fb({state_q[25], state_q[27], state_q[29], state_q[31]}),
              fa({state_q[33], state_q[35], state_q[37], state_q[39]}),
              fb({state_q[41], state_q[43], state_q[45], state_q[47]})}];
    word_step = (fsm_q == WORD) && !KEY_LOAD;
    single = (fsm_q == IDLE) && STB && !WORD_STB && !KEY_LOAD;
    start = (fsm_q == IDLE) && WORD_STB && !KEY_LOAD;
    last = word_step && (&cnt_q);
    fbit = word_step ? word_q[cnt_q ^ 5'd24] : BIT_IN;
    enc = word_step ? enc_q : ENC_FB;
    fb_in = (^(state_q & TAPS)) ^ fbit ^ (enc & ks);
    acc_d = acc_q;
    acc_d[cnt_q ^ 5'd24] = ks;
    fsm_d = KEY_LOAD ? IDLE : start ? WORD : last ? IDLE : fsm_q;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) fsm_q <= IDLE;
    else fsm_q <= fsm_d;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= '0;
      word_q <= '0;
      acc_q <= '0;
      ks_word_q <= '0;
      cnt_q <= '0;
      enc_q <= 1'b0;
      ks_bit_q <= 1'b0;
      ks_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      keyed_q <= 1'b0;
    end else begin
      ks_valid_q <= single;
      word_done_q <= last;
      if (single) ks_bit_q <= ks;
      if (KEY_LOAD) begin
        state_q <= KEY;
        keyed_q <= 1'b1;
        cnt_q <= '0;
      end else if (start) begin
        word_q <= WORD_IN;
        enc_q <= WORD_ENC;
        cnt_q <= '0;
      end else if (single || word_step) begin
        state_q <= {fb_in, state_q[47:1]};
      end
      if (word_step) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 5'd1;
      end
      if (last) ks_word_q <= acc_d;
    end
  end
  assign KS_VALID = ks_valid_q;
  assign KS_BIT = ks_bit_q;
  assign WORD_DONE = word_done_q;
  assign KS_WORD = ks_word_q;
  assign BUSY = (fsm_q == WORD);
  assign KEYED = keyed_q;
  assign STATE = state_q;
endmodule

// File: tb/tb_crypto1_keystream.sv
// tb_crypto1_keystream: randomized check of crypto1_keystream against a table-driven Crypto1 model.
module tb_crypto1_keystream;
  logic        clk = 1'b0, rst = 1'b1;
  logic        key_load = 0, stb = 0, bit_in = 0, enc_fb = 0, word_stb = 0, word_enc = 0;
  logic [47:0] key = '0;
  logic [31:0] word_in = '0;
  logic        ks_valid, ks_bit, word_done, busy, keyed;
  logic [31:0] ks_word;
  logic [47:0] state;
  int          errors = 0, checks = 0;
  logic [47:0] m_s;
  localparam logic [15:0] TFA = 16'h2C79;
  localparam logic [15:0] TFB = 16'h6671;
  localparam logic [31:0] TFC = 32'h7907287B;
  localparam int TAP[18] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};

  crypto1_keystream dut (
    .CLK(clk), .RESET(rst), .KEY_LOAD(key_load), .KEY(key), .STB(stb), .BIT_IN(bit_in),
    .ENC_FB(enc_fb), .WORD_STB(word_stb), .WORD_IN(word_in), .WORD_ENC(word_enc),
    .KS_VALID(ks_valid), .KS_BIT(ks_bit), .WORD_DONE(word_done), .KS_WORD(ks_word),
    .BUSY(busy), .KEYED(keyed), .STATE(state)
  );

  always #5 clk = ~clk;

  function automatic int tbl4(input logic [15:0] t, input logic [47:0] s, input int b);
    int idx;
    idx = 8 * s[b] + 4 * s[b + 2] + 2 * s[b + 4] + s[b + 6];
    return int'(t[15 - idx]);
  endfunction

  function automatic logic m_ks(input logic [47:0] s);
    int idx;
    idx = 16 * tbl4(TFA, s, 9) + 8 * tbl4(TFB, s, 17) + 4 * tbl4(TFB, s, 25)
        + 2 * tbl4(TFA, s, 33) + tbl4(TFB, s, 41);
    return TFC[31 - idx];
  endfunction

  function automatic logic [47:0] m_step(input logic [47:0] s, input logic f, input logic e);
    logic x;
    x = f ^ (e & m_ks(s));
    for (int j = 0; j < 18; j++) x ^= s[TAP[j]];
    return (s >> 1) | (48'(x) << 47);
  endfunction

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [47:0] k);
    key_load = 1; key = k;
    tick;
    key_load = 0;
    m_s = k;
    check("load_state", state, k);
    check("load_keyed", 48'(keyed), 48'd1);
    check("load_busy", 48'(busy), 48'd0);
  endtask

  task automatic single(input logic b, input logic e);
    logic ek;
    ek = m_ks(m_s);
    m_s = m_step(m_s, b, e);
    stb = 1; bit_in = b; enc_fb = e;
    tick;
    stb = 0;
    check("step_valid", 48'(ks_valid), 48'd1);
    check("step_ks", 48'(ks_bit), 48'(ek));
    check("step_state", state, m_s);
  endtask

  task automatic run_word(input logic [31:0] w, input logic e);
    logic [31:0] ew;
    ew = '0;
    for (int n = 0; n < 32; n++) begin
      ew[n ^ 24] = m_ks(m_s);
      m_s = m_step(m_s, w[n ^ 24], e);
    end
    word_stb = 1; word_in = w; word_enc = e; stb = 1'($urandom);
    tick;
    word_stb = 0; word_in = $urandom; word_enc = 1'($urandom);
    for (int i = 0; i < 32; i++) begin
      check("word_busy", 48'(busy), 48'd1);
      check("word_early_done", 48'(word_done), 48'd0);
      check("word_valid", 48'(ks_valid), 48'd0);
      stb = 1'($urandom); word_stb = 1'($urandom);
      tick;
    end
    stb = 0; word_stb = 0;
    check("word_end_busy", 48'(busy), 48'd0);
    check("word_done", 48'(word_done), 48'd1);
    check("word_ks", 48'(ks_word), 48'(ew));
    check("word_state", state, m_s);
    tick;
    check("word_done_pulse", 48'(word_done), 48'd0);
    check("word_ks_hold", 48'(ks_word), 48'(ew));
  endtask

  initial begin
    logic [47:0] k;
    logic [31:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_keyed", 48'(keyed), 48'd0);
    check("rst_valid", 48'(ks_valid), 48'd0);
    check("rst_done", 48'(word_done), 48'd0);
    rst = 0;
    m_s = '0;
    single(1'b1, 1'b0);
    check("unkeyed_keyed", 48'(keyed), 48'd0);
    load(48'd0);
    for (int i = 0; i < 4; i++) begin
      single(1'b0, 1'b0);
      check("zero_ks", 48'(ks_bit), 48'd0);
      check("zero_state", state, 48'd0);
    end
    single(1'b1, 1'b0);
    check("z1_ks", 48'(ks_bit), 48'd0);
    check("z1_state", state, 48'h8000_0000_0000);
    single(1'b0, 1'b0);
    check("z2_ks", 48'(ks_bit), 48'd1);
    tick;
    check("valid_pulse", 48'(ks_valid), 48'd0);
    for (int r = 0; r < 4; r++) begin
      k = {16'($urandom), 32'($urandom)};
      load(k);
      run_word($urandom, 1'b0);
      run_word($urandom, 1'b1);
      for (int i = 0; i < 64; i++) single(1'($urandom), 1'($urandom));
    end
    held = ks_word;
    k = {16'($urandom), 32'($urandom)};
    word_stb = 1; word_in = $urandom; word_enc = 1'($urandom);
    tick;
    word_stb = 0;
    repeat (10) tick;
    check("abort_busy_pre", 48'(busy), 48'd1);
    load(k);
    check("abort_done", 48'(word_done), 48'd0);
    repeat (25) begin
      tick;
      check("abort_no_done", 48'(word_done), 48'd0);
    end
    check("abort_ks_hold", 48'(ks_word), 48'(held));
    check("abort_state_idle", state, k);
    k = {16'($urandom), 32'($urandom)};
    key_load = 1; key = k; stb = 1; word_stb = 1; word_in = $urandom;
    tick;
    key_load = 0; stb = 0; word_stb = 0;
    m_s = k;
    check("coll_state", state, k);
    check("coll_valid", 48'(ks_valid), 48'd0);
    check("coll_busy", 48'(busy), 48'd0);
    tick;
    check("coll_busy2", 48'(busy), 48'd0);
    check("coll_state2", state, k);
    word_stb = 1; word_in = $urandom; word_enc = 0;
    tick;
    word_stb = 0;
    repeat (20) tick;
    #2 rst = 1;
    #1;
    check("arst_state", state, 48'd0);
    check("arst_busy", 48'(busy), 48'd0);
    check("arst_keyed", 48'(keyed), 48'd0);
    check("arst_ksword", 48'(ks_word), 48'd0);
    check("arst_ksbit", 48'(ks_bit), 48'd0);
    check("arst_valid", 48'(ks_valid), 48'd0);
    check("arst_done", 48'(word_done), 48'd0);
    tick;
    rst = 0;
    m_s = '0;
    repeat (35) begin
      tick;
      check("arst_no_done", 48'(word_done), 48'd0);
    end
    single(1'b1, 1'b0);
    check("resume_state", state, 48'h8000_0000_0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crypto1_keystream.md
CRYPTO1_KEYSTREAM -- requirements
Module: crypto1_keystream

Interface
REQ-001 The block SHALL have one port per line, listed below, with clock and reset first.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- KEY_LOAD  in  1  one-cycle strobe; loads KEY into the LFSR.
- KEY  in  48  key; KEY[i] loads state bit x_i.
- STB  in  1  single-step strobe.
- BIT_IN  in  1  input bit for a single step.
- ENC_FB  in  1  for a single step, selects encrypted feed (BIT_IN xor ks).
- WORD_STB  in  1  starts a 32-step word feed.
- WORD_IN  in  32  word to feed.
- WORD_ENC  in  1  encrypted feed for the whole word; sampled at WORD_STB.
- KS_VALID  out  1  one-cycle pulse; KS_BIT is valid.
- KS_BIT  out  1  keystream bit of the last single step.
- WORD_DONE  out  1  one-cycle pulse; KS_WORD is valid.
- KS_WORD  out  32  keystream of the last word.
- BUSY  out  1  a word feed is in progress.
- KEYED  out  1  a key has been loaded since reset.
- STATE  out  48  current LFSR state; STATE[i] = x_i.

REQ-002 The block SHALL have no parameters.

Function
REQ-003 Filter, evaluated on the current state before the shift: ks = fc(fa(x9,x11,x13,x15), fb(x17,x19,x21,x23), fb(x25,x27,x29,x31), fa(x33,x35,x37,x39), fb(x41,x43,x45,x47)).
REQ-004 Filter tables SHALL be fa = 16'h2C79, fb = 16'h6671, fc = 32'h7907287B.
- Table index is MSB-first: fa/fb index = 8*y0 + 4*y1 + 2*y2 + y3, output = table bit (15 - index).
- fc index = 16*a + 8*b + 4*c + 2*d + e, output = table bit (31 - index).
REQ-005 Each step SHALL compute fb_in = x0^x5^x9^x10^x12^x14^x15^x17^x19^x24^x25^x27^x29^x35^x39^x41^x42^x43^in, where in = feed bit, or feed bit ^ ks when encrypted.
REQ-006 Each step SHALL shift: x_i <= x_(i+1) for i = 0..46, and x47 <= fb_in.
REQ-007 KEY_LOAD SHALL set STATE = KEY and KEYED = 1 on the next edge, abort any word in progress (BUSY = 0, no WORD_DONE), and take precedence over WORD_STB and STB in the same cycle.
REQ-008 Single step (STB with BUSY = 0, no KEY_LOAD):
- one shift per STB;
- KS_BIT = ks of the pre-shift state and KS_VALID = 1, both on the next edge (latency 1).
- Back-to-back STB SHALL be supported at one step per cycle.
REQ-009 Word feed (WORD_STB with BUSY = 0, no KEY_LOAD):
- WORD_IN and WORD_ENC SHALL be latched, and BUSY = 1 from the next cycle for exactly 32 cycles.
- Step n (n = 0..31) SHALL use feed bit WORD_IN[n ^ 24] and write ks into KS_WORD[n ^ 24].
- WORD_DONE SHALL pulse on the cycle BUSY falls; KS_WORD SHALL be stable until the next word completes.
REQ-010 Step counter: 5-bit, counts 0..31, returns to 0 after step 31.
REQ-011 FSM states: IDLE (BUSY = 0) and WORD (BUSY = 1).
- IDLE -> WORD on an accepted WORD_STB.
- WORD -> IDLE after step 31, or on KEY_LOAD.
REQ-012 Inputs while BUSY = 1:
- STB and WORD_STB SHALL be ignored;
- KS_VALID SHALL stay 0 during a word feed.
REQ-013 WORD_STB and STB in the same cycle: WORD_STB wins and STB is dropped.
REQ-014 Stepping with KEYED = 0 SHALL operate on the current state (all-zero after reset); KEYED is status only.

Reset
REQ-015 RESET high SHALL asynchronously clear STATE, KS_BIT, KS_VALID, KS_WORD, WORD_DONE, BUSY, KEYED, the step counter and the FSM (to IDLE).
REQ-016 RESET asserted mid-word SHALL abort the word with no WORD_DONE; operation SHALL resume on the first edge after RESET falls.

Verification
REQ-017 Zero key: KEY_LOAD with KEY = 0, then 4 STB with BIT_IN = 0 -> KS_BIT = 0 each step; STATE stays 0.
REQ-018 Zero key, STB with BIT_IN = 1, ENC_FB = 0 -> KS_BIT = 0 and STATE = 48'h8000_0000_0000; a following STB with BIT_IN = 0 -> KS_BIT = 1.
REQ-019 Word timing: WORD_STB -> BUSY high for 32 cycles, WORD_DONE once on the 32nd cycle; STB pulses during the word change nothing.
REQ-020 Golden model: random 48-bit keys, random 32-bit word feeds plus 64 single steps, plain and encrypted feed -> KS_BIT, KS_WORD and STATE match the crapto1 C model bit-exactly.
REQ-021 Abort: KEY_LOAD at word step 10 -> STATE = KEY next cycle, BUSY = 0, no WORD_DONE; RESET at word step 20 -> all outputs 0.
REQ-022 Collisions: KEY_LOAD with STB and WORD_STB in the same cycle -> key loaded, no step taken, KS_VALID = 0.
